// File: rtl/cpu_control_pkg.sv
// Shared types and encodings for the CPU control unit: FSM states, instruction
// classes, memory/writeback codes and the registered control-word layout.
package cpu_control_pkg;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
        S_WR_IMM, S_GET_A, S_GET_B, S_CALC, S_WR_REG,
        S_ADDR, S_LD_ADDR, S_MEM_RD, S_WB_MEM,
        S_PASS_B, S_MEM_WR, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_MOV_IMM, C_MOV_REG, C_MVN, C_ADD, C_AND,
        C_CMP, C_LDR, C_STR, C_HALT
    } instr_class_t;

    localparam logic [2:0] OP_LDR = 3'b011;
    localparam logic [2:0] OP_STR = 3'b100;
    localparam logic [2:0] OP_ALU = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] VSEL_MDATA = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b01;
    localparam logic [1:0] VSEL_C     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{reset_pc: 1'b1, load_pc: 1'b1, default: '0};

    function automatic instr_class_t classify(input logic [2:0] op, input logic [1:0] sub);
        instr_class_t c;
        c = C_HALT;
        case ({op, sub})
            {OP_MOV, 2'b10}: c = C_MOV_IMM;
            {OP_MOV, 2'b00}: c = C_MOV_REG;
            {OP_ALU, 2'b11}: c = C_MVN;
            {OP_ALU, 2'b00}: c = C_ADD;
            {OP_ALU, 2'b10}: c = C_AND;
            {OP_ALU, 2'b01}: c = C_CMP;
            {OP_LDR, 2'b00}: c = C_LDR;
            {OP_STR, 2'b00}: c = C_STR;
            default:         c = C_HALT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_control_instr_dec.sv
// Instruction decoder: splits the IR into register/shift fields, sign-extends
// the immediates and classifies the instruction for FSM dispatch.
module cpu_control_instr_dec
    import cpu_control_pkg::*;
(
    input  logic [15:0]  ir,
    output logic [1:0]   sub,
    output logic [2:0]   rn,
    output logic [2:0]   rd,
    output logic [1:0]   sh,
    output logic [2:0]   rm,
    output logic [15:0]  sximm5,
    output logic [15:0]  sximm8,
    output instr_class_t iclass
);

    assign sub    = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign iclass = classify(ir[15:13], ir[12:11]);

endmodule

// File: rtl/cpu_control.sv
// Control unit FSM: fetch / decode / execute sequencing for the 16-bit datapath.
// Outputs are registered alongside the state, so they are a pure function of state + IR.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  RST       | reset held: clear PC
//  IF1/IF2   | read instruction at PC; IF2 latches IR
//  UPD_PC    | advance PC
//  DECODE    | dispatch on op/sub
//  WR_IMM    | Rn <= sximm8
//  GET_A/B   | load A (Rn) / B (Rm, or Rd for STR)
//  CALC      | ALU op into C (status only for CMP)
//  WR_REG    | Rd <= C
//  ADDR      | C <= A + sximm5
//  LD_ADDR   | address register <= C
//  MEM_RD    | read data memory
//  WB_MEM    | Rd <= mdata
//  PASS_B    | C <= B (store data)
//  MEM_WR    | write data memory
//  HALT      | stopped until reset
module cpu_control
    import cpu_control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir_in,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_addr,
    output logic        addr_sel,
    output logic [1:0]  mem_cmd,
    output logic        halted
);

    state_t       state, state_nxt;
    ctrl_t        ctrl, ctrl_nxt;
    logic [15:0]  ir;
    logic [1:0]   sub, sh;
    logic [2:0]   rn, rd, rm;
    instr_class_t iclass;

    cpu_control_instr_dec u_dec (
        .ir     (ir),
        .sub    (sub),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm5 (sximm5),
        .sximm8 (sximm8),
        .iclass (iclass)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:     state_nxt = S_IF1;
            S_IF1:     state_nxt = S_IF2;
            S_IF2:     state_nxt = S_UPD_PC;
            S_UPD_PC:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (iclass)
                    C_MOV_IMM:                   state_nxt = S_WR_IMM;
                    C_MOV_REG, C_MVN:            state_nxt = S_GET_B;
                    C_ADD, C_AND, C_CMP,
                    C_LDR, C_STR:                state_nxt = S_GET_A;
                    default:                     state_nxt = S_HALT;
                endcase
            end
            S_WR_IMM:  state_nxt = S_IF1;
            S_GET_A:   state_nxt = (iclass == C_LDR || iclass == C_STR) ? S_ADDR : S_GET_B;
            S_GET_B:   state_nxt = (iclass == C_STR) ? S_PASS_B : S_CALC;
            S_CALC:    state_nxt = (iclass == C_CMP) ? S_IF1 : S_WR_REG;
            S_WR_REG:  state_nxt = S_IF1;
            S_ADDR:    state_nxt = S_LD_ADDR;
            S_LD_ADDR: state_nxt = (iclass == C_STR) ? S_GET_B : S_MEM_RD;
            S_MEM_RD:  state_nxt = S_WB_MEM;
            S_WB_MEM:  state_nxt = S_IF1;
            S_PASS_B:  state_nxt = S_MEM_WR;
            S_MEM_WR:  state_nxt = S_IF1;
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_HALT;
        endcase
    end

    // Control word for the state being entered; IR is already stable whenever it matters.
    always_comb begin
        ctrl_nxt = '0;
        case (state_nxt)
            S_RST:     ctrl_nxt = CTRL_RST;
            S_IF1: begin
                ctrl_nxt.addr_sel = 1'b1;
                ctrl_nxt.mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                ctrl_nxt.addr_sel = 1'b1;
                ctrl_nxt.mem_cmd  = MEM_READ;
                ctrl_nxt.load_ir  = 1'b1;
            end
            S_UPD_PC:  ctrl_nxt.load_pc = 1'b1;
            S_WR_IMM: begin
                ctrl_nxt.writenum = rn;
                ctrl_nxt.vsel     = VSEL_IMM8;
                ctrl_nxt.write    = 1'b1;
            end
            S_GET_A: begin
                ctrl_nxt.readnum = rn;
                ctrl_nxt.loada   = 1'b1;
            end
            S_GET_B: begin
                ctrl_nxt.readnum = (iclass == C_STR) ? rd : rm;
                ctrl_nxt.loadb   = 1'b1;
            end
            S_CALC: begin
                ctrl_nxt.shift  = sh;
                ctrl_nxt.alu_op = (iclass == C_MOV_REG) ? ALU_ADD : sub;
                ctrl_nxt.asel   = (iclass == C_MOV_REG);
                ctrl_nxt.loads  = (iclass == C_CMP);
                ctrl_nxt.loadc  = (iclass != C_CMP);
            end
            S_WR_REG: begin
                ctrl_nxt.writenum = rd;
                ctrl_nxt.vsel     = VSEL_C;
                ctrl_nxt.write    = 1'b1;
            end
            S_ADDR: begin
                ctrl_nxt.bsel   = 1'b1;
                ctrl_nxt.alu_op = ALU_ADD;
                ctrl_nxt.loadc  = 1'b1;
            end
            S_LD_ADDR: ctrl_nxt.load_addr = 1'b1;
            S_MEM_RD:  ctrl_nxt.mem_cmd   = MEM_READ;
            S_WB_MEM: begin
                ctrl_nxt.mem_cmd  = MEM_READ;
                ctrl_nxt.vsel     = VSEL_MDATA;
                ctrl_nxt.writenum = rd;
                ctrl_nxt.write    = 1'b1;
            end
            S_PASS_B: begin
                ctrl_nxt.asel  = 1'b1;
                ctrl_nxt.loadc = 1'b1;
            end
            S_MEM_WR:  ctrl_nxt.mem_cmd = MEM_WRITE;
            S_HALT:    ctrl_nxt.halted  = 1'b1;
            default:   ctrl_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RST;
            ctrl  <= CTRL_RST;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            ctrl  <= ctrl_nxt;
            if (ctrl.load_ir)
                ir <= ir_in;
        end
    end

    assign readnum   = ctrl.readnum;
    assign writenum  = ctrl.writenum;
    assign write     = ctrl.write;
    assign loada     = ctrl.loada;
    assign loadb     = ctrl.loadb;
    assign loadc     = ctrl.loadc;
    assign loads     = ctrl.loads;
    assign asel      = ctrl.asel;
    assign bsel      = ctrl.bsel;
    assign vsel      = ctrl.vsel;
    assign shift     = ctrl.shift;
    assign ALUop     = ctrl.alu_op;
    assign load_ir   = ctrl.load_ir;
    assign load_pc   = ctrl.load_pc;
    assign reset_pc  = ctrl.reset_pc;
    assign load_addr = ctrl.load_addr;
    assign addr_sel  = ctrl.addr_sel;
    assign mem_cmd   = ctrl.mem_cmd;
    assign halted    = ctrl.halted;

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: directed and random instructions compared cycle by cycle
// against a per-instruction step list built from the ISA description.
module tb_cpu_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ir_in;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, shift, ALUop, mem_cmd;
    logic [15:0] sximm5, sximm8;
    logic        load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;

    int errors = 0;
    int checks = 0;

    cpu_control dut (
        .clk(clk), .reset(reset), .ir_in(ir_in),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
        .sximm5(sximm5), .sximm8(sximm8),
        .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
        .load_addr(load_addr), .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write, loada, loadb, loadc, loads, asel, bsel;
        logic [1:0] vsel, shift, aluop;
        logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } vec_t;

    vec_t obs;
    always_comb obs = {readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel,
                       vsel, shift, ALUop, load_ir, load_pc, reset_pc, load_addr, addr_sel,
                       mem_cmd, halted};

    vec_t exp_q[$];
    bit   exp_halt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] sext_model(input logic [15:0] instr, input int bits);
        int v;
        v = int'(instr) % (1 << bits);
        if (v >= (1 << (bits - 1))) v = v - (1 << bits);
        return v[15:0];
    endfunction

    function automatic vec_t v_rst();
        vec_t e = '0;
        e.reset_pc = 1'b1;
        e.load_pc  = 1'b1;
        return e;
    endfunction

    function automatic vec_t v_fetch(input bit ld);
        vec_t e = '0;
        e.addr_sel = 1'b1;
        e.mem_cmd  = 2'b01;
        e.load_ir  = ld;
        return e;
    endfunction

    task automatic push_read(input logic [2:0] r, input bit to_a);
        vec_t e = '0;
        e.readnum = r;
        if (to_a) e.loada = 1'b1; else e.loadb = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_alu(input logic [1:0] op, input logic [1:0] sh,
                            input bit zero_a, input bit imm_b, input bit status);
        vec_t e = '0;
        e.aluop = op;
        e.shift = sh;
        e.asel  = zero_a;
        e.bsel  = imm_b;
        e.loads = status;
        e.loadc = !status;
        exp_q.push_back(e);
    endtask

    task automatic push_write(input logic [2:0] r, input logic [1:0] vs, input logic [1:0] mc);
        vec_t e = '0;
        e.writenum = r;
        e.vsel     = vs;
        e.write    = 1'b1;
        e.mem_cmd  = mc;
        exp_q.push_back(e);
    endtask

    task automatic push_mem(input logic [1:0] mc);
        vec_t e = '0;
        e.mem_cmd = mc;
        exp_q.push_back(e);
    endtask

    // Cycle-by-cycle expectation from IF2 through the next IF1 (or a run of HALT cycles).
    task automatic build(input logic [15:0] instr);
        logic [2:0] rn, rd, rm;
        logic [1:0] sub, sh;
        vec_t       e;
        rn = instr[10:8]; rd = instr[7:5]; rm = instr[2:0];
        sub = instr[12:11]; sh = instr[4:3];
        exp_q.delete();
        exp_halt = 1'b0;
        exp_q.push_back(v_fetch(1'b1));
        e = '0; e.load_pc = 1'b1; exp_q.push_back(e);
        exp_q.push_back('0);
        case (instr[15:11])
            5'b110_10: push_write(rn, 2'b01, 2'b00);
            5'b110_00: begin
                push_read(rm, 1'b0); push_alu(2'b00, sh, 1'b1, 1'b0, 1'b0);
                push_write(rd, 2'b11, 2'b00);
            end
            5'b101_11: begin
                push_read(rm, 1'b0); push_alu(2'b11, sh, 1'b0, 1'b0, 1'b0);
                push_write(rd, 2'b11, 2'b00);
            end
            5'b101_00, 5'b101_10: begin
                push_read(rn, 1'b1); push_read(rm, 1'b0);
                push_alu(sub, sh, 1'b0, 1'b0, 1'b0); push_write(rd, 2'b11, 2'b00);
            end
            5'b101_01: begin
                push_read(rn, 1'b1); push_read(rm, 1'b0);
                push_alu(2'b01, sh, 1'b0, 1'b0, 1'b1);
            end
            5'b011_00: begin
                push_read(rn, 1'b1); push_alu(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
                e = '0; e.load_addr = 1'b1; exp_q.push_back(e);
                push_mem(2'b01); push_write(rd, 2'b00, 2'b01);
            end
            5'b100_00: begin
                push_read(rn, 1'b1); push_alu(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
                e = '0; e.load_addr = 1'b1; exp_q.push_back(e);
                push_read(rd, 1'b0); push_alu(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
                push_mem(2'b10);
            end
            default: begin
                exp_halt = 1'b1;
                e = '0; e.halted = 1'b1;
                repeat (6) exp_q.push_back(e);
            end
        endcase
        if (!exp_halt) exp_q.push_back(v_fetch(1'b0));
    endtask

    // Enter with the DUT in IF1; limit < 0 runs the whole expectation list.
    task automatic run_instr(input logic [15:0] instr, input int limit);
        ir_in = instr;
        build(instr);
        for (int i = 0; i < exp_q.size() && (limit < 0 || i < limit); i++) begin
            @(posedge clk); #1;
            chk($sformatf("instr %h step %0d", instr, i), 32'(obs), 32'(exp_q[i]));
            if (i == 2) begin
                chk($sformatf("sximm5 %h", instr), 32'(sximm5), 32'(sext_model(instr, 5)));
                chk($sformatf("sximm8 %h", instr), 32'(sximm8), 32'(sext_model(instr, 8)));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset state", 32'(obs), 32'(v_rst()));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("first IF1", 32'(obs), 32'(v_fetch(1'b0)));
    endtask

    function automatic logic [15:0] rand_instr();
        logic [31:0] r;
        logic [2:0]  op;
        logic [1:0]  sub;
        logic [2:0]  bad_ops [4];
        bad_ops = '{3'b000, 3'b001, 3'b010, 3'b111};
        r = $urandom;
        case ($urandom_range(0, 8))
            0: begin op = 3'b110; sub = 2'b10; end
            1: begin op = 3'b110; sub = 2'b00; end
            2: begin op = 3'b101; sub = 2'b11; end
            3: begin op = 3'b101; sub = 2'b00; end
            4: begin op = 3'b101; sub = 2'b10; end
            5: begin op = 3'b101; sub = 2'b01; end
            6: begin op = 3'b011; sub = 2'b00; end
            7: begin op = 3'b100; sub = 2'b00; end
            default: begin op = bad_ops[$urandom_range(0, 3)]; sub = r[12:11]; end
        endcase
        return {op, sub, r[10:0]};
    endfunction

    initial begin
        logic [15:0] instr;
        reset = 1'b1;
        ir_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'(obs), 32'(v_rst()));
        chk("reset sximm5", 32'(sximm5), 32'h0);
        chk("reset sximm8", 32'(sximm8), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("first IF1", 32'(obs), 32'(v_fetch(1'b0)));

        run_instr(16'hD105, -1);
        chk("MOV R1,#5 sximm8", 32'(sximm8), 32'h0005);
        run_instr(16'hD0FF, -1);
        chk("MOV R0,#-1 sximm8", 32'(sximm8), 32'hFFFF);
        run_instr(16'hA2A8, -1);
        run_instr(16'hA900, -1);
        run_instr(16'h8040, -1);
        run_instr(16'h6030, -1);
        run_instr(16'h7030, -1);
        chk("imm5 of 7030", 32'(sximm5), 32'hFFF0);
        do_reset();
        run_instr(16'hE000, -1);
        do_reset();

        for (int n = 0; n < 120; n++) begin
            instr = rand_instr();
            run_instr(instr, -1);
            if (exp_halt) do_reset();
        end

        // Reset while the LDR sits in MEM_RD: the write-back cycle must never appear.
        run_instr(16'h6030, 7);
        do_reset();
        run_instr(16'hD105, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
